// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: widths, operator and category
// codes, divider state encodings and the HI/LO pair payload.
package ex_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned ALU_OPERATOR_W = 8;
    localparam int unsigned ALU_CATEGORY_W = 3;
    localparam int unsigned DIV_ITERATIONS = 32;
    localparam int unsigned DIV_COUNT_W    = 6;
    localparam int unsigned DIV_STATE_W    = 2;

    localparam logic [DATA_W-1:0]      ZERO_WORD = '0;
    localparam logic [DIV_COUNT_W-1:0] DIV_LAST  = DIV_COUNT_W'(DIV_ITERATIONS - 1);

    localparam logic [ALU_CATEGORY_W-1:0] CAT_NOP    = 3'd0;
    localparam logic [ALU_CATEGORY_W-1:0] CAT_LOGIC  = 3'd1;
    localparam logic [ALU_CATEGORY_W-1:0] CAT_SHIFT  = 3'd2;
    localparam logic [ALU_CATEGORY_W-1:0] CAT_ARITH  = 3'd3;
    localparam logic [ALU_CATEGORY_W-1:0] CAT_MOVE   = 3'd4;
    localparam logic [ALU_CATEGORY_W-1:0] CAT_MULDIV = 3'd5;

    localparam logic [ALU_OPERATOR_W-1:0] OP_NOP   = 8'h00;
    localparam logic [ALU_OPERATOR_W-1:0] OP_OR    = 8'h25;
    localparam logic [ALU_OPERATOR_W-1:0] OP_AND   = 8'h24;
    localparam logic [ALU_OPERATOR_W-1:0] OP_XOR   = 8'h26;
    localparam logic [ALU_OPERATOR_W-1:0] OP_NOR   = 8'h27;
    localparam logic [ALU_OPERATOR_W-1:0] OP_SLL   = 8'h7C;
    localparam logic [ALU_OPERATOR_W-1:0] OP_SRL   = 8'h02;
    localparam logic [ALU_OPERATOR_W-1:0] OP_SRA   = 8'h03;
    localparam logic [ALU_OPERATOR_W-1:0] OP_ADDU  = 8'h21;
    localparam logic [ALU_OPERATOR_W-1:0] OP_SUBU  = 8'h23;
    localparam logic [ALU_OPERATOR_W-1:0] OP_SLT   = 8'h2A;
    localparam logic [ALU_OPERATOR_W-1:0] OP_SLTU  = 8'h2B;
    localparam logic [ALU_OPERATOR_W-1:0] OP_MFHI  = 8'h10;
    localparam logic [ALU_OPERATOR_W-1:0] OP_MTHI  = 8'h11;
    localparam logic [ALU_OPERATOR_W-1:0] OP_MFLO  = 8'h12;
    localparam logic [ALU_OPERATOR_W-1:0] OP_MTLO  = 8'h13;
    localparam logic [ALU_OPERATOR_W-1:0] OP_MULT  = 8'h18;
    localparam logic [ALU_OPERATOR_W-1:0] OP_MULTU = 8'h19;
    localparam logic [ALU_OPERATOR_W-1:0] OP_DIV   = 8'h1A;
    localparam logic [ALU_OPERATOR_W-1:0] OP_DIVU  = 8'h1B;

    localparam logic [DIV_STATE_W-1:0] DIV_IDLE = 2'b00;
    localparam logic [DIV_STATE_W-1:0] DIV_BUSY = 2'b01;
    localparam logic [DIV_STATE_W-1:0] DIV_DONE = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

    function automatic logic is_divide(input logic [ALU_OPERATOR_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative restoring divider: one quotient bit per cycle over 32 cycles,
// signed mode handled on magnitudes with a sign fix-up on the way out.
module divider
    import ex_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DIV_STATE_W-1:0] state_q, state_d;
    logic [2*DATA_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]      divisor_q, divisor_d;
    logic [DIV_COUNT_W-1:0] count_q, count_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q, neg_rem_d;

    logic [DATA_W-1:0] dividend_mag, divisor_mag;
    logic [DATA_W:0]   partial, trial;

    assign dividend_mag = (signed_mode && dividend[DATA_W-1]) ? (ZERO_WORD - dividend) : dividend;
    assign divisor_mag  = (signed_mode && divisor[DATA_W-1])  ? (ZERO_WORD - divisor)  : divisor;

    // Remainder shifted left with the next dividend bit brought in.
    assign partial = acc_q[2*DATA_W-1:DATA_W-1];
    assign trial   = partial - {1'b0, divisor_q};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        divisor_d  = divisor_q;
        count_d    = count_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;

        case (state_q)
            DIV_IDLE: begin
                if (start && !abort) begin
                    if (divisor == ZERO_WORD) begin
                        // Divide by zero: quotient all ones, remainder is the raw dividend.
                        state_d    = DIV_DONE;
                        acc_d      = {dividend, ~ZERO_WORD};
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                    end else begin
                        state_d    = DIV_BUSY;
                        acc_d      = {ZERO_WORD, dividend_mag};
                        divisor_d  = divisor_mag;
                        count_d    = '0;
                        neg_quot_d = signed_mode & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        neg_rem_d  = signed_mode & dividend[DATA_W-1];
                    end
                end
            end
            DIV_BUSY: begin
                if (partial >= {1'b0, divisor_q}) begin
                    acc_d = {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {partial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
                end
                count_d = count_q + DIV_COUNT_W'(1);
                if (count_q == DIV_LAST) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        if (abort) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= DIV_IDLE;
            acc_q      <= '0;
            divisor_q  <= '0;
            count_q    <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            divisor_q  <= divisor_d;
            count_q    <= count_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    assign busy      = (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = neg_quot_q ? (ZERO_WORD - acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0];
    assign remainder = neg_rem_q  ? (ZERO_WORD - acc_q[2*DATA_W-1:DATA_W]) : acc_q[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/ex.sv
// MIPS execute stage: combinational ALU, HI/LO register pair, and the stall
// request that holds the upstream pipeline while a divide is in flight.
module ex
    import ex_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ALU_OPERATOR_W-1:0] alu_operator,
    input  logic [ALU_CATEGORY_W-1:0] alu_category,
    input  logic [DATA_W-1:0]         alu_operand1,
    input  logic [DATA_W-1:0]         alu_operand2,
    input  logic                      write_enable,
    input  logic [REG_ADDR_W-1:0]     write_addr,
    input  logic                      flush,
    output logic                      ex_write_enable,
    output logic [REG_ADDR_W-1:0]     ex_write_addr,
    output logic [DATA_W-1:0]         ex_write_data,
    output logic                      stall_request
);

    hilo_t               hilo_q, hilo_d;
    logic                div_req, div_signed, div_busy, div_done;
    logic [DATA_W-1:0]   quotient, remainder;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_wen;
    logic [2*DATA_W-1:0] product;
    logic [4:0]          shamt;
    logic                is_mult;

    assign div_req    = (alu_category == CAT_MULDIV) && is_divide(alu_operator);
    assign div_signed = (alu_operator == OP_DIV);
    assign is_mult    = (alu_category == CAT_MULDIV) &&
                        ((alu_operator == OP_MULT) || (alu_operator == OP_MULTU));
    assign shamt      = alu_operand1[4:0];

    divider u_divider (
        .clock       (clock),
        .reset       (reset),
        .start       (div_req),
        .signed_mode (div_signed),
        .dividend    (alu_operand1),
        .divisor     (alu_operand2),
        .abort       (flush),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    // Operands are extended to 64 bits so one multiplier serves both signednesses.
    always_comb begin
        if (alu_operator == OP_MULT) begin
            product = {{DATA_W{alu_operand1[DATA_W-1]}}, alu_operand1} *
                      {{DATA_W{alu_operand2[DATA_W-1]}}, alu_operand2};
        end else begin
            product = {ZERO_WORD, alu_operand1} * {ZERO_WORD, alu_operand2};
        end
    end

    always_comb begin
        alu_result = ZERO_WORD;
        alu_wen    = write_enable;
        case (alu_category)
            CAT_LOGIC: begin
                case (alu_operator)
                    OP_OR:   alu_result = alu_operand1 | alu_operand2;
                    OP_AND:  alu_result = alu_operand1 & alu_operand2;
                    OP_XOR:  alu_result = alu_operand1 ^ alu_operand2;
                    OP_NOR:  alu_result = ~(alu_operand1 | alu_operand2);
                    default: alu_result = ZERO_WORD;
                endcase
            end
            CAT_SHIFT: begin
                case (alu_operator)
                    OP_SLL:  alu_result = alu_operand2 << shamt;
                    OP_SRL:  alu_result = alu_operand2 >> shamt;
                    OP_SRA:  alu_result = $unsigned($signed(alu_operand2) >>> shamt);
                    default: alu_result = ZERO_WORD;
                endcase
            end
            CAT_ARITH: begin
                case (alu_operator)
                    OP_ADDU: alu_result = alu_operand1 + alu_operand2;
                    OP_SUBU: alu_result = alu_operand1 - alu_operand2;
                    OP_SLT:  alu_result = {31'd0, $signed(alu_operand1) < $signed(alu_operand2)};
                    OP_SLTU: alu_result = {31'd0, alu_operand1 < alu_operand2};
                    default: alu_result = ZERO_WORD;
                endcase
            end
            CAT_MOVE: begin
                case (alu_operator)
                    OP_MFHI: alu_result = hilo_q.hi;
                    OP_MFLO: alu_result = hilo_q.lo;
                    OP_MTHI: alu_wen    = 1'b0;
                    OP_MTLO: alu_wen    = 1'b0;
                    default: alu_result = ZERO_WORD;
                endcase
            end
            CAT_MULDIV: begin
                case (alu_operator)
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_wen = 1'b0;
                    default: alu_result = ZERO_WORD;
                endcase
            end
            default: alu_result = ZERO_WORD;
        endcase
    end

    // A flush cancels every HI/LO update issued in the same cycle.
    always_comb begin
        hilo_d = hilo_q;
        if (!flush) begin
            if (div_done) begin
                hilo_d = {remainder, quotient};
            end else if (is_mult) begin
                hilo_d = product;
            end else if ((alu_category == CAT_MOVE) && (alu_operator == OP_MTHI)) begin
                hilo_d.hi = alu_operand1;
            end else if ((alu_category == CAT_MOVE) && (alu_operator == OP_MTLO)) begin
                hilo_d.lo = alu_operand1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hilo_q <= '0;
        end else begin
            hilo_q <= hilo_d;
        end
    end

    assign ex_write_enable = reset & alu_wen;
    assign ex_write_addr   = reset ? write_addr : '0;
    assign ex_write_data   = reset ? alu_result : ZERO_WORD;
    assign stall_request   = reset & ~flush & ((div_req & ~div_busy & ~div_done) | div_busy);

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for the execute stage: the driver pushes expected outputs from
// a timeline-level model; a negedge monitor pops and compares them.
module tb_ex;
    import ex_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  alu_operator = OP_OR;
    logic [2:0]  alu_category = CAT_LOGIC;
    logic [31:0] alu_operand1 = 32'h0000_1100;
    logic [31:0] alu_operand2 = 32'h0000_0101;
    logic        write_enable = 1'b1;
    logic [4:0]  write_addr = 5'd5;
    logic        flush = 1'b0;
    logic        ex_write_enable;
    logic [4:0]  ex_write_addr;
    logic [31:0] ex_write_data;
    logic        stall_request;

    ex dut (
        .clock(clock), .reset(reset),
        .alu_operator(alu_operator), .alu_category(alu_category),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .write_enable(write_enable), .write_addr(write_addr), .flush(flush),
        .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr),
        .ex_write_data(ex_write_data), .stall_request(stall_request)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: architectural HI/LO plus a divide timeline (age since issue).
    logic [31:0] m_hi = '0, m_lo = '0;
    bit          m_div_active = 0;
    int          m_div_age = 0, m_div_len = 0;
    logic [31:0] m_div_q = '0, m_div_r = '0;

    function automatic void model_alu(input logic [2:0] cat, input logic [7:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic we, output logic en, output logic [31:0] data);
        int n;
        n    = int'(a[4:0]);
        en   = we;
        data = '0;
        case (cat)
            CAT_LOGIC: case (op)
                OP_OR:  data = a | b;
                OP_AND: data = a & b;
                OP_XOR: data = a ^ b;
                OP_NOR: data = ~(a | b);
                default: ;
            endcase
            CAT_SHIFT: case (op)
                OP_SLL: data = b << n;
                OP_SRL: data = b >> n;
                OP_SRA: data = (b >> n) | (b[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
                default: ;
            endcase
            CAT_ARITH: case (op)
                OP_ADDU: data = a + b;
                OP_SUBU: data = a - b;
                OP_SLT:  data = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                OP_SLTU: data = (a < b) ? 32'd1 : 32'd0;
                default: ;
            endcase
            CAT_MOVE: case (op)
                OP_MFHI: data = m_hi;
                OP_MFLO: data = m_lo;
                OP_MTHI, OP_MTLO: en = 1'b0;
                default: ;
            endcase
            CAT_MULDIV: case (op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: en = 1'b0;
                default: ;
            endcase
            default: ;
        endcase
    endfunction

    task automatic drive_cycle(input logic [2:0] cat, input logic [7:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic we, input logic [4:0] wa, input logic fl,
                               input string name, input bit fixed = 0,
                               input logic [31:0] fixed_data = '0);
        exp_t        e;
        logic        en;
        logic [31:0] data;
        bit          issue;
        longint      sa, sb, sp;
        logic [63:0] up;
        @(posedge clock);
        #1;
        reset = 1'b1; alu_category = cat; alu_operator = op;
        alu_operand1 = a; alu_operand2 = b; write_enable = we; write_addr = wa; flush = fl;

        model_alu(cat, op, a, b, we, en, data);
        issue   = (cat == CAT_MULDIV) && (op == OP_DIV || op == OP_DIVU) && !m_div_active && !fl;
        e.en    = en;
        e.addr  = wa;
        e.data  = fixed ? fixed_data : data;
        e.stall = !fl && (issue || (m_div_active && m_div_age < m_div_len));
        exp_q.push_back(e);
        name_q.push_back(name);

        // State as seen after the coming clock edge.
        if (fl) begin
            m_div_active = 0;
        end else begin
            if (m_div_active) begin
                if (m_div_age == m_div_len) begin
                    m_hi = m_div_r; m_lo = m_div_q; m_div_active = 0;
                end else begin
                    m_div_age++;
                end
            end
            if (cat == CAT_MULDIV && op == OP_MULT) begin
                sp = longint'(int'(a)) * longint'(int'(b));
                m_hi = sp[63:32]; m_lo = sp[31:0];
            end else if (cat == CAT_MULDIV && op == OP_MULTU) begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
            end else if (cat == CAT_MOVE && op == OP_MTHI) begin
                m_hi = a;
            end else if (cat == CAT_MOVE && op == OP_MTLO) begin
                m_lo = a;
            end
            if (issue) begin
                m_div_active = 1;
                m_div_age    = 1;
                if (b == 32'd0) begin
                    m_div_len = 1; m_div_q = 32'hFFFF_FFFF; m_div_r = a;
                end else begin
                    m_div_len = 33;
                    if (op == OP_DIV) begin
                        sa = longint'(int'(a)); sb = longint'(int'(b));
                        m_div_q = 32'(sa / sb); m_div_r = 32'(sa % sb);
                    end else begin
                        m_div_q = a / b; m_div_r = a % b;
                    end
                end
            end
        end
    endtask

    task automatic drive_reset(input string name);
        exp_t e;
        @(posedge clock);
        #1;
        reset = 1'b0;
        e = '0;
        exp_q.push_back(e);
        name_q.push_back(name);
        m_hi = '0; m_lo = '0; m_div_active = 0;
    endtask

    task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input string name);
        int k;
        k = 0;
        do begin
            drive_cycle(CAT_MULDIV, op, a, b, 1'b1, 5'd3, k == flush_at, name);
            k++;
        end while (m_div_active && k < 40);
    endtask

    function automatic void pick_op(input int idx, output logic [2:0] cat, output logic [7:0] op);
        case (idx)
            0:  begin cat = CAT_LOGIC;  op = OP_OR;    end
            1:  begin cat = CAT_LOGIC;  op = OP_AND;   end
            2:  begin cat = CAT_LOGIC;  op = OP_XOR;   end
            3:  begin cat = CAT_LOGIC;  op = OP_NOR;   end
            4:  begin cat = CAT_SHIFT;  op = OP_SLL;   end
            5:  begin cat = CAT_SHIFT;  op = OP_SRL;   end
            6:  begin cat = CAT_SHIFT;  op = OP_SRA;   end
            7:  begin cat = CAT_ARITH;  op = OP_ADDU;  end
            8:  begin cat = CAT_ARITH;  op = OP_SUBU;  end
            9:  begin cat = CAT_ARITH;  op = OP_SLT;   end
            10: begin cat = CAT_ARITH;  op = OP_SLTU;  end
            11: begin cat = CAT_MOVE;   op = OP_MFHI;  end
            12: begin cat = CAT_MOVE;   op = OP_MFLO;  end
            13: begin cat = CAT_MOVE;   op = OP_MTHI;  end
            14: begin cat = CAT_MOVE;   op = OP_MTLO;  end
            15: begin cat = CAT_MULDIV; op = OP_MULT;  end
            16: begin cat = CAT_MULDIV; op = OP_MULTU; end
            17: begin cat = CAT_NOP;    op = 8'($urandom); end
            default: begin cat = CAT_LOGIC; op = OP_ADDU; end
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if ({ex_write_enable, ex_write_addr, ex_write_data, stall_request} !== e) begin
                errors++;
                $display("FAIL %s: got en=%0b addr=%0d data=%h stall=%0b, expected en=%0b addr=%0d data=%h stall=%0b",
                         n, ex_write_enable, ex_write_addr, ex_write_data, stall_request,
                         e.en, e.addr, e.data, e.stall);
            end
        end
    end

    initial begin
        logic [2:0]  cat;
        logic [7:0]  op;
        logic [31:0] a, b;
        drive_reset("reset_hold_0");
        drive_reset("reset_hold_1");

        drive_cycle(CAT_LOGIC, OP_OR, 32'h0000_1100, 32'h0000_0101, 1'b1, 5'd5, 1'b0, "or", 1, 32'h0000_1101);
        drive_cycle(CAT_SHIFT, OP_SRA, 32'd4, 32'h8000_0000, 1'b1, 5'd6, 1'b0, "sra", 1, 32'hF800_0000);
        drive_cycle(CAT_SHIFT, OP_SLL, 32'd0, 32'hDEAD_BEEF, 1'b1, 5'd6, 1'b0, "sll_zero", 1, 32'hDEAD_BEEF);
        drive_cycle(CAT_SHIFT, OP_SRL, 32'd8, 32'h8000_00FF, 1'b1, 5'd6, 1'b0, "srl", 1, 32'h0080_0000);
        drive_cycle(CAT_ARITH, OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd7, 1'b0, "slt", 1, 32'd1);
        drive_cycle(CAT_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd7, 1'b0, "sltu", 1, 32'd0);
        drive_cycle(CAT_ARITH, OP_ADDU, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd8, 1'b0, "addu_wrap", 1, 32'd0);
        drive_cycle(CAT_NOP, OP_OR, 32'h1234_5678, 32'h1, 1'b1, 5'd9, 1'b0, "nop", 1, 32'd0);

        drive_cycle(CAT_MULDIV, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 5'd2, 1'b0, "mult", 1, 32'd0);
        drive_cycle(CAT_MOVE, OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd2, 1'b0, "mult_hi", 1, 32'hFFFF_FFFF);
        drive_cycle(CAT_MOVE, OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd2, 1'b0, "mult_lo", 1, 32'hFFFF_FFFA);

        do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, "div_neg7_2");
        drive_cycle(CAT_MOVE, OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd4, 1'b0, "div_lo", 1, 32'hFFFF_FFFD);
        drive_cycle(CAT_MOVE, OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd4, 1'b0, "div_hi", 1, 32'hFFFF_FFFF);

        do_div(OP_DIVU, 32'd7, 32'd0, -1, "divu_by_zero");
        drive_cycle(CAT_MOVE, OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd4, 1'b0, "div0_lo", 1, 32'hFFFF_FFFF);
        drive_cycle(CAT_MOVE, OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd4, 1'b0, "div0_hi", 1, 32'd7);

        do_div(OP_DIVU, 32'd100, 32'd3, 10, "divu_flush");
        drive_cycle(CAT_MOVE, OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd4, 1'b0, "flush_hi", 1, 32'd7);
        drive_cycle(CAT_MOVE, OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd4, 1'b0, "flush_lo", 1, 32'hFFFF_FFFF);
        drive_cycle(CAT_MULDIV, OP_DIV, 32'd9, 32'd2, 1'b1, 5'd3, 1'b1, "flush_blocks_start", 1, 32'd0);

        for (int k = 0; k < 5; k++) begin
            drive_cycle(CAT_MULDIV, OP_DIV, 32'd1000, 32'd7, 1'b1, 5'd3, 1'b0, "div_before_reset");
        end
        drive_reset("reset_mid_busy_0");
        drive_reset("reset_mid_busy_1");
        drive_cycle(CAT_MOVE, OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd4, 1'b0, "post_reset_hi", 1, 32'd0);
        drive_cycle(CAT_MOVE, OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd4, 1'b0, "post_reset_lo", 1, 32'd0);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = 32'($urandom_range(1, 9));
                    2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    default: ;
                endcase
                do_div(($urandom_range(0, 1) == 1) ? OP_DIV : OP_DIVU, a, b,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 35)) : -1, "rand_div");
            end else begin
                pick_op(int'($urandom_range(0, 18)), cat, op);
                if ($urandom_range(0, 3) == 0) a[4:0] = 5'd0;
                drive_cycle(cat, op, a, b, 1'($urandom), 5'($urandom), $urandom_range(0, 9) == 0, "rand_alu");
            end
        end

        drive_cycle(CAT_MOVE, OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd1, 1'b0, "final_hi");
        drive_cycle(CAT_MOVE, OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd1, 1'b0, "final_lo");
        @(posedge clock);
        @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage MIPS pipeline, sitting between the decode stage and the `ex_mem` pipeline register. It consumes the decoded operator, category, operands and destination, and produces the `ex_write_*` result that decode forwards from and that `ex_mem` latches. It owns the HI/LO register pair and an iterative 32-cycle divider. The divider raises `stall_request` to freeze the upstream pipeline.

## Interface
Parameters: none. Widths come from the shared macro file.
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `alu_operator`  in  `ALU_OPERATOR_BUS`  operation code from decode
- `alu_category`  in  `ALU_CATEGORY_BUS`  category: NOP, LOGIC, SHIFT, ARITH, MOVE, MULDIV
- `alu_operand1`  in  32  first operand; for SHIFT, bits [4:0] are the shift amount
- `alu_operand2`  in  32  second operand; for SHIFT, the value shifted
- `write_enable`  in  1  decode's register-write request
- `write_addr`  in  5  destination register
- `flush`  in  1  synchronous abort of any in-flight divide
- `ex_write_enable`  out  1  result valid for GPR write (combinational)
- `ex_write_addr`  out  5  destination (combinational)
- `ex_write_data`  out  32  result (combinational)
- `stall_request`  out  1  hold the upstream stages this cycle

## Operation
- LOGIC: OR, AND, XOR, NOR, bitwise.
- SHIFT:
  - SLL and SRL zero-fill.
  - SRA replicates operand2[31].
  - A shift amount of 0 returns operand2.
- ARITH:
  - ADDU and SUBU wrap modulo 2^32 with no overflow trap.
  - SLT is a signed compare and SLTU an unsigned compare; both return 32'd1 or 32'd0.
- MOVE:
  - MFHI and MFLO return HI and LO.
  - MTHI and MTLO load operand1 into HI or LO at the next edge, with `ex_write_enable`=0.
- MULDIV:
  - Common to all four: `ex_write_enable`=0 and `ex_write_data`=0.
  - MULT and MULTU form a single-cycle 64-bit product, HI = [63:32] and LO = [31:0], written at the next edge.
  - DIV and DIVU hand off to the divider.
  - DIV and DIVU: LO = quotient, HI = remainder.
- NOP category, or an unknown operator within a category: `ex_write_data`=0, with enable and address passed through unchanged.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when a DIV/DIVU is presented and the divisor is nonzero; the iteration counter loads 0.
  - IDLE -> DONE directly when the divisor is 0. The result is then LO = 32'hFFFF_FFFF and HI = the dividend.
  - BUSY: one restoring iteration per cycle; after iteration 31 completes, go to DONE.
  - DONE: HI/LO are committed at the edge leaving DONE; the next state is IDLE.
  - Signed DIV works on magnitudes. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
  - A divide is started only from IDLE. The DIV still held in decode during DONE does not restart the divider.
- `flush`=1 forces the next state to IDLE and discards the partial result. HI/LO are unchanged. It also suppresses any HI/LO write that cycle.
- Reset (`reset`=0, asynchronous):
  - HI and LO go to 0 and the FSM to IDLE.
  - `ex_write_enable`, `ex_write_addr`, `ex_write_data` and `stall_request` all read 0 while reset is held.
  - Reset during BUSY aborts the divide.

## Timing
- Every non-divide result appears in the same cycle as its inputs: zero latency, combinational.
- HI/LO writes from MULT, MTHI and MTLO are visible to an MFHI/MFLO issued in the next cycle.
- DIV issued in cycle 0:
  - `stall_request`=1 in cycles 0 through 32, covering the issue cycle in IDLE and 32 BUSY cycles.
  - Cycle 33 is DONE with `stall_request`=0. HI/LO update at the end of cycle 33.
  - An MFLO issued in cycle 34 sees the quotient.
- Divide by zero: `stall_request`=1 in cycle 0 only; DONE in cycle 1.
- If `flush` and a new DIV coincide in IDLE, `flush` wins: no start, and `stall_request`=0.

## Structure
- Shared macro file:
  - operator codes and category codes
  - divider state encodings
  - `ZERO_WORD`
  - divider iteration count (32)
- Sub-module `divider`:
  - inputs: clock, reset, start, signed_mode, dividend, divisor, abort
  - outputs: busy, done, quotient, remainder
  - internals: the FSM, the 64-bit shift register and the 6-bit counter
- `ex` keeps the HI/LO registers, the combinational ALU and the stall logic.

## Test plan
- OR of 32'h0000_1100 with 32'h0000_0101, `write_enable`=1, `write_addr`=5 -> `ex_write_data`=32'h0000_1101, addr 5, enable 1, in the same cycle.
- SRA, amount 4, value 32'h8000_0000 -> 32'hF800_0000. SLT(-1, 1) -> 1. SLTU(-1, 1) -> 0. ADDU(32'hFFFF_FFFF, 1) -> 0.
- MULT(-2, 3), then MFHI and MFLO on the following cycles -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- DIV(-7, 2):
  - `stall_request` high for exactly 33 cycles.
  - Then LO=32'hFFFF_FFFD (-3) and HI=32'hFFFF_FFFF (-1).
  - DIVU(7, 0) -> LO=32'hFFFF_FFFF, HI=7 after a 1-cycle stall.
- `flush` asserted at cycle 10 of a DIVU -> FSM is IDLE next cycle, `stall_request`=0, and HI/LO keep their prior values.
- Reset dropped mid-BUSY -> all outputs 0 immediately, and HI/LO read 0 after reset is released.
